// File: rtl/s3g_pkg.sv
// s3g_pkg: shared S3G transmit-path state encoding and payload limits
package s3g_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } s3g_state_t;
    localparam logic [7:0] S3G_MAX_PAYLOAD = 8'd15;
    localparam int S3G_BUF_W = 128;
endpackage

// File: rtl/s3g_tx_arb.sv
// s3g_tx_arb: round-robin arbiter feeding two requesters into one S3G transmitter
module s3g_tx_arb
    import s3g_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [7:0]           req0_len,
    input  logic [S3G_BUF_W-1:0] req0_data,
    input  logic                 req1_valid,
    input  logic [7:0]           req1_len,
    input  logic [S3G_BUF_W-1:0] req1_data,
    output logic                 req0_ack,
    output logic                 req0_nak,
    output logic                 req1_ack,
    output logic                 req1_nak,
    output logic                 tx_packet_wr,
    output logic [7:0]           tx_payload_len,
    output logic [S3G_BUF_W-1:0] tx_buf,
    input  logic                 tx_busy,
    output logic                 busy,
    output logic                 stall_err,
    output logic [15:0]          pkt_cnt
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    s3g_state_t state;
    logic last_grant;
    logic [TMO_W-1:0] tmo;
    logic pick1, arb, win_ok;
    logic [7:0] win_len;
    logic [S3G_BUF_W-1:0] win_data;

    // Winner selection: requester 1 wins alone, or on a tie when requester 0 was granted last
    always_comb begin
        pick1    = req1_valid && (!req0_valid || !last_grant);
        win_len  = pick1 ? req1_len : req0_len;
        win_data = pick1 ? req1_data : req0_data;
        win_ok   = win_len <= S3G_MAX_PAYLOAD;
        arb      = (state == IDLE) && !tx_busy && (req0_valid || req1_valid);
    end

    assign busy = state != IDLE;

    // Control FSM with registered strobes, payload latch, packet counter and stall watchdog
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            tmo            <= '0;
            req0_ack       <= 1'b0;
            req0_nak       <= 1'b0;
            req1_ack       <= 1'b0;
            req1_nak       <= 1'b0;
            tx_packet_wr   <= 1'b0;
            tx_payload_len <= '0;
            tx_buf         <= '0;
            stall_err      <= 1'b0;
            pkt_cnt        <= '0;
        end else begin
            req0_ack     <= 1'b0;
            req0_nak     <= 1'b0;
            req1_ack     <= 1'b0;
            req1_nak     <= 1'b0;
            tx_packet_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb) begin
                        last_grant <= pick1;
                        if (win_ok) begin
                            state          <= ISSUE;
                            tx_packet_wr   <= 1'b1;
                            tx_payload_len <= win_len;
                            tx_buf         <= win_data;
                            pkt_cnt        <= pkt_cnt + 16'd1;
                            req0_ack       <= !pick1;
                            req1_ack       <= pick1;
                        end else begin
                            req0_nak <= !pick1;
                            req1_nak <= pick1;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT_BUSY;
                    tmo   <= '0;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (tmo == TMO_LAST) begin
                        state     <= IDLE;
                        stall_err <= 1'b1;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                WAIT_DONE: state <= tx_busy ? WAIT_DONE : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_s3g_tx_arb.sv
// tb_s3g_tx_arb: randomized and directed scoreboard bench for the S3G transmit arbiter
module tb_s3g_tx_arb;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_len = '0, req1_len = '0;
    logic [127:0] req0_data = '0, req1_data = '0;
    logic tx_busy = 1'b0;
    logic req0_ack, req0_nak, req1_ack, req1_nak, tx_packet_wr, busy, stall_err;
    logic [7:0] tx_payload_len;
    logic [127:0] tx_buf;
    logic [15:0] pkt_cnt;

    always #5 clk = ~clk;

    s3g_tx_arb #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_len(req0_len), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_len(req1_len), .req1_data(req1_data),
        .req0_ack(req0_ack), .req0_nak(req0_nak), .req1_ack(req1_ack), .req1_nak(req1_nak),
        .tx_packet_wr(tx_packet_wr), .tx_payload_len(tx_payload_len), .tx_buf(tx_buf),
        .tx_busy(tx_busy), .busy(busy), .stall_err(stall_err), .pkt_cnt(pkt_cnt)
    );

    typedef struct {
        logic [7:0]   len;
        logic [127:0] data;
    } pkt_t;
    typedef struct {
        logic [3:0]   code;
        logic [7:0]   len;
        logic [127:0] data;
        logic [15:0]  cnt;
    } exp_t;

    pkt_t rq0[$], rq1[$], na[$], nb[$];
    exp_t sb[$];
    exp_t mon_e;
    int vectors = 0, miscompares = 0;
    bit m_last = 1'b1;
    logic [15:0] m_cnt = '0;
    bit m_stall = 1'b0;
    int t_delay = 1, t_hold = 3;
    bit t_stall = 1'b0, t_active = 1'b0;
    int since = 0;
    bit have_prev = 1'b0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: condition occurred, expected it not to", name);
    endtask

    function automatic pkt_t mk(int len);
        pkt_t p;
        p.len  = 8'(len);
        p.data = {$urandom, $urandom, $urandom, $urandom};
        return p;
    endfunction

    task automatic present();
        req0_valid = rq0.size() > 0;
        req1_valid = rq1.size() > 0;
        if (req0_valid) begin
            req0_len  = rq0[0].len;
            req0_data = rq0[0].data;
        end
        if (req1_valid) begin
            req1_len  = rq1[0].len;
            req1_data = rq1[0].data;
        end
    endtask

    // Reference model: replay the round-robin rule over the queued packets to get the event order
    task automatic load_batch();
        int i = 0, j = 0;
        bit w;
        pkt_t p;
        exp_t e;
        @(negedge clk);
        while (i < na.size() || j < nb.size()) begin
            if (i < na.size() && j < nb.size()) w = !m_last;
            else w = j < nb.size();
            if (w) begin p = nb[j]; j++; end
            else begin p = na[i]; i++; end
            e.len  = p.len;
            e.data = p.data;
            if (p.len <= 8'd15) begin
                m_cnt++;
                e.code = w ? 4'b0010 : 4'b0001;
            end else begin
                e.code = w ? 4'b1000 : 4'b0100;
            end
            e.cnt = m_cnt;
            sb.push_back(e);
            m_last = w;
        end
        rq0 = na;
        rq1 = nb;
        na.delete();
        nb.delete();
        present();
    endtask

    task automatic wait_idle(string tag);
        int n = 0;
        @(negedge clk);
        while (!(rq0.size() == 0 && rq1.size() == 0 && sb.size() == 0 && !busy && !t_active && !tx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            fail({tag, "_idle_timeout"});
            rq0.delete();
            rq1.delete();
            sb.delete();
            present();
        end
    endtask

    task automatic wait_strobe(string tag);
        int n = 0;
        while (!tx_packet_wr && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!tx_packet_wr) fail({tag, "_no_strobe"});
    endtask

    task automatic do_reset(int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        chk("rst_flags", {req0_ack, req0_nak, req1_ack, req1_nak, tx_packet_wr, busy, stall_err}, 7'd0);
        chk("rst_pkt_cnt", pkt_cnt, 16'd0);
        chk("rst_len", tx_payload_len, 8'd0);
        chk("rst_buf", tx_buf, 128'd0);
        m_last  = 1'b1;
        m_cnt   = '0;
        m_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Requesters: retire the head packet on ack/nak and present the next one
    initial forever begin
        @(posedge clk);
        #1;
        if ((req0_ack || req0_nak) && rq0.size() > 0) rq0.delete(0);
        if ((req1_ack || req1_nak) && rq1.size() > 0) rq1.delete(0);
        present();
    end

    // Transmitter model: raise tx_busy t_delay cycles after a strobe for t_hold cycles, or never when stalling
    initial forever begin
        @(posedge clk);
        #1;
        if (tx_packet_wr && rst_n) begin
            t_active = 1'b1;
            if (!t_stall) begin
                repeat (t_delay) @(posedge clk);
                #1;
                tx_busy = 1'b1;
                repeat (t_hold) @(posedge clk);
                #1;
                tx_busy = 1'b0;
            end
            t_active = 1'b0;
        end
    end

    // Monitor: every ack/nak pops the scoreboard; strobes must pair with acks and be spaced apart
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            have_prev = 1'b0;
        end else begin
            since++;
            if (tx_packet_wr && !(req0_ack || req1_ack)) fail("strobe_without_ack");
            if (tx_packet_wr) begin
                if (have_prev) chk("strobe_spacing_ge4", since >= 4, 1'b1);
                have_prev = 1'b1;
                since = 0;
            end
            if ({req1_nak, req0_nak, req1_ack, req0_ack} != 4'd0) begin
                if (sb.size() == 0) begin
                    fail("unexpected_ack_nak");
                end else begin
                    mon_e = sb.pop_front();
                    chk("event_code", {req1_nak, req0_nak, req1_ack, req0_ack}, mon_e.code);
                    chk("event_strobe", tx_packet_wr, mon_e.code[1:0] != 2'b00);
                    chk("event_pkt_cnt", pkt_cnt, mon_e.cnt);
                    if (mon_e.code[1:0] != 2'b00) begin
                        chk("event_len", tx_payload_len, mon_e.len);
                        chk("event_buf", tx_buf, mon_e.data);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        pkt_t p;
        do_reset(3);

        t_delay = 1;
        t_hold  = 20;
        p.len   = 8'd3;
        p.data  = {104'd0, 8'd33, 8'd22, 8'd11};
        na.push_back(p);
        load_batch();
        wait_idle("single");
        chk("single_pkt_cnt", pkt_cnt, 16'd1);
        chk("single_busy_after", busy, 1'b0);
        chk("single_len_held", tx_payload_len, 8'd3);
        chk("single_buf_held", tx_buf, {104'd0, 8'd33, 8'd22, 8'd11});

        do_reset(2);
        t_hold = 2;
        for (int i = 0; i < 3; i++) begin
            na.push_back(mk(i + 1));
            nb.push_back(mk(i + 8));
        end
        load_batch();
        wait_idle("tie");
        chk("tie_pkt_cnt", pkt_cnt, 16'd6);

        nb.push_back(mk(16));
        load_batch();
        wait_idle("badlen");
        chk("badlen_pkt_cnt", pkt_cnt, 16'd6);
        na.push_back(mk(15));
        load_batch();
        wait_idle("len15");
        na.push_back(mk(0));
        load_batch();
        wait_idle("len0");

        for (int b = 0; b < 15; b++) begin
            repeat ($urandom_range(0, 4)) na.push_back(mk($urandom_range(0, 19)));
            repeat ($urandom_range(0, 4)) nb.push_back(mk($urandom_range(0, 19)));
            t_delay = $urandom_range(1, 4);
            t_hold  = $urandom_range(1, 6);
            load_batch();
            wait_idle("random");
        end
        chk("random_pkt_cnt", pkt_cnt, m_cnt);
        chk("random_stall_err", stall_err, 1'b0);

        t_stall = 1'b1;
        na.push_back(mk(5));
        load_batch();
        wait_strobe("stall");
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_busy_cycles", n, TIMEOUT + 1);
        chk("stall_err_set", stall_err, 1'b1);
        t_stall = 1'b0;
        wait_idle("stall");
        t_delay = 2;
        t_hold  = 3;
        nb.push_back(mk(9));
        load_batch();
        wait_idle("post_stall");
        chk("stall_err_sticky", stall_err, 1'b1);

        t_delay = 1;
        t_hold  = 30;
        na.push_back(mk(7));
        load_batch();
        wait_strobe("midrst");
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_busy_before", busy, 1'b1);
        do_reset(1);
        nb.push_back(mk(2));
        load_batch();
        wait_idle("midrst_next");
        chk("midrst_next_cnt", pkt_cnt, 16'd1);

        t_hold = 2;
        @(negedge clk);
        force dut.pkt_cnt = 16'hFFFF;
        #1;
        release dut.pkt_cnt;
        m_cnt = 16'hFFFF;
        na.push_back(mk(4));
        load_batch();
        wait_idle("wrap");
        chk("wrap_zero", pkt_cnt, 16'h0000);
        nb.push_back(mk(6));
        load_batch();
        wait_idle("wrap_next");
        chk("wrap_next", pkt_cnt, 16'h0001);

        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
